// File: rtl/noc_pio_port.sv
// noc_pio_port: multi-channel PIO endpoint for the NOC.
// Inputs are synchronised and debounced per channel. Each debounced change is
// reported as a DPCR packet through a round-robin arbiter with a valid/ready
// handshake. DPCR write packets load the per-channel output registers.
module noc_pio_port #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 10,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_CH*CH_W-1:0] pio_in,
  output logic [NUM_CH*CH_W-1:0] pio_out,
  output logic [31:0]            dpcr_out_data,
  output logic                   dpcr_out_valid,
  input  logic                   dpcr_out_ready,
  input  logic [31:0]            dpcr_in_data,
  input  logic                   dpcr_in_valid
);

  localparam int             CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [4:0]     NUM_CH_W = 5'(NUM_CH);

  logic [NUM_CH-1:0]      pend_vec;
  logic [NUM_CH-1:0]      grant_vec;
  logic [NUM_CH*CH_W-1:0] snap_flat;
  logic [3:0]             rr_ptr_reg;
  logic                   load_en;
  logic                   grant_found;
  logic [3:0]             grant_idx;
  logic [15:0]            grant_ext;
  logic [15:0]            snap_sel;
  logic [3:0]             rr_next;
  logic [3:0]             wr_id;
  logic                   wr_en;
  logic                   unused_in_bits;

  // The output register may take a new packet when empty or being consumed.
  assign load_en = !dpcr_out_valid || dpcr_out_ready;

  // Round-robin search: first pending channel at or after rr_ptr, with wrap.
  always_comb begin
    logic [15:0] pend_ext;
    logic [4:0]  cand;
    pend_ext    = 16'(pend_vec);
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_reg} + 5'(i);
      if (cand >= NUM_CH_W) cand = cand - NUM_CH_W;
      if (!grant_found && pend_ext[cand[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[3:0];
      end
    end
  end

  // Grant one-hot, the granted channel's snapshot, and the next pointer.
  always_comb begin
    grant_ext = (load_en && grant_found) ? (16'd1 << grant_idx) : 16'd0;
    grant_vec = grant_ext[NUM_CH-1:0];
    snap_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == 4'(k)) snap_sel = 16'(snap_flat[k*CH_W +: CH_W]);
    end
    if (({1'b0, grant_idx} + 5'd1) >= NUM_CH_W) rr_next = 4'd0;
    else                                        rr_next = grant_idx + 4'd1;
  end

  // Report packet register; data is only replaced on a load, so it holds while stalled.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dpcr_out_data  <= '0;
      dpcr_out_valid <= 1'b0;
      rr_ptr_reg     <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        dpcr_out_data  <= {1'b1, 3'b000, grant_idx, 8'h00, snap_sel};
        dpcr_out_valid <= 1'b1;
        rr_ptr_reg     <= rr_next;
      end else begin
        dpcr_out_valid <= 1'b0;
      end
    end
  end

  // Write decode: only flagged packets addressed to an existing channel.
  assign wr_id = dpcr_in_data[27:24];
  assign wr_en = dpcr_in_valid && dpcr_in_data[31] && ({1'b0, wr_id} < NUM_CH_W);
  assign unused_in_bits = ^{dpcr_in_data[30:28], dpcr_in_data[23:CH_W]};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CH_W-1:0]  sync1_reg;
    logic [CH_W-1:0]  sync2_reg;
    logic [CH_W-1:0]  deb_reg;
    logic [CH_W-1:0]  snap_reg;
    logic [CH_W-1:0]  out_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pend_reg;
    logic             fire;

    // The count restarts whenever the synchronised value is still moving
    // (first stage differs from second), so only a steady new value matures.
    assign fire = (sync2_reg != deb_reg) && (sync1_reg == sync2_reg) && (cnt_reg == CNT_MAX);

    // Synchroniser, debounce counter and pending flag; a new change wins over a grant.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        sync1_reg <= '0;
        sync2_reg <= '0;
        deb_reg   <= '0;
        snap_reg  <= '0;
        cnt_reg   <= '0;
        pend_reg  <= 1'b0;
      end else begin
        sync1_reg <= pio_in[gi*CH_W +: CH_W];
        sync2_reg <= sync1_reg;
        if (sync2_reg == deb_reg || sync1_reg != sync2_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          deb_reg  <= sync2_reg;
          snap_reg <= sync2_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (fire)               pend_reg <= 1'b1;
        else if (grant_vec[gi]) pend_reg <= 1'b0;
      end
    end

    // Output register loaded by an accepted write addressed to this channel.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)                 out_reg <= '0;
      else if (wr_en && wr_id == 4'(gi)) out_reg <= dpcr_in_data[CH_W-1:0];
    end

    assign pend_vec[gi]                  = pend_reg;
    assign snap_flat[gi*CH_W +: CH_W]    = snap_reg;
    assign pio_out[gi*CH_W +: CH_W]      = out_reg;
  end

endmodule

// File: tb/tb_noc_pio_port.sv
// Testbench for noc_pio_port: directed stimulus, expected packets queued in a
// scoreboard and checked by an independent monitor on the falling edge.
module tb_noc_pio_port;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 10;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH*CH_W-1:0] pio_in;
  logic [NUM_CH*CH_W-1:0] pio_out;
  logic [31:0]            dpcr_out_data;
  logic                   dpcr_out_valid;
  logic                   dpcr_out_ready;
  logic [31:0]            dpcr_in_data;
  logic                   dpcr_in_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [9:0]  exp_out[NUM_CH];

  logic [31:0] wr_data[6] = '{32'h8200_03FF, 32'h8500_0001, 32'h8400_0001,
                              32'h0200_0155, 32'h8000_0155, 32'h8300_0200};
  bit          wr_acc[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  noc_pio_port #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DEBOUNCE_CYC(16)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .pio_in         (pio_in),
    .pio_out        (pio_out),
    .dpcr_out_data  (dpcr_out_data),
    .dpcr_out_valid (dpcr_out_valid),
    .dpcr_out_ready (dpcr_out_ready),
    .dpcr_in_data   (dpcr_in_data),
    .dpcr_in_valid  (dpcr_in_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks data stays put while stalled.
  always @(negedge clk) begin
    if (dpcr_out_valid && stall_prev) check("stall_hold", 64'(dpcr_out_data), 64'(prev_data));
    if (dpcr_out_valid && dpcr_out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_packet: got 0x%08h expected none", dpcr_out_data);
      end else begin
        mon_exp = sb.pop_front();
        check("packet", 64'(dpcr_out_data), 64'(mon_exp));
        $display("packet 0x%08h (expected 0x%08h)", dpcr_out_data, mon_exp);
      end
    end
    stall_prev <= dpcr_out_valid && !dpcr_out_ready;
    prev_data  <= dpcr_out_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [9:0] v);
    pio_in[k*CH_W +: CH_W] = v;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (dpcr_out_valid) break;
    end
    if (i == max_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no valid within %0d cycles expected valid", name, max_cyc);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !dpcr_out_valid) break;
    end
    if (i == max_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d packets outstanding expected 0", name, sb.size());
    end
  endtask

  function automatic logic [39:0] exp_pio();
    return {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    pio_in         = '0;
    dpcr_out_ready = 1'b0;
    dpcr_in_data   = '0;
    dpcr_in_valid  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) exp_out[k] = '0;

    // 1: reset state, single report with latency and hold-until-ready
    tick(3);
    check("reset_valid", 64'(dpcr_out_valid), 64'd0);
    check("reset_data", 64'(dpcr_out_data), 64'd0);
    check("reset_pio_out", 64'(pio_out), 64'd0);
    rst_n = 1'b1;
    tick(5);
    check("idle_no_packet", 64'(dpcr_out_valid), 64'd0);
    set_ch(1, 10'h155);
    sb.push_back(32'h8100_0155);
    tick(18);
    check("latency_pre", 64'(dpcr_out_valid), 64'd0);
    tick(1);
    check("latency_valid", 64'(dpcr_out_valid), 64'd1);
    check("first_data", 64'(dpcr_out_data), 64'h8100_0155);
    tick(5);
    check("held_valid", 64'(dpcr_out_valid), 64'd1);
    dpcr_out_ready = 1'b1;
    wait_idle("drain_t1", 20);

    // 2: short glitch, then a change of value that must restart the count
    set_ch(0, 10'h003);
    tick(10);
    set_ch(0, 10'h007);
    tick(10);
    set_ch(0, 10'h000);
    tick(30);
    check("glitch_no_packet", 64'(dpcr_out_valid), 64'd0);

    // 3: three simultaneous changes after a fresh reset -> ids 0, 2, 3 back to back
    tick(1);
    pio_in = '0;
    rst_n  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    set_ch(0, 10'h011);
    set_ch(2, 10'h022);
    set_ch(3, 10'h033);
    sb.push_back(32'h8000_0011);
    sb.push_back(32'h8200_0022);
    sb.push_back(32'h8300_0033);
    wait_valid("t3_valid", 40);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(dpcr_out_valid), 64'd1);
    end
    @(negedge clk);
    check("b2b_end", 64'(dpcr_out_valid), 64'd0);
    wait_idle("drain_t3", 10);

    // 4: output stalled while ch2 steps 1 -> 2 -> 3; only the latest ch2 value is sent
    tick(1);
    dpcr_out_ready = 1'b0;
    set_ch(3, 10'h044);
    sb.push_back(32'h8300_0044);
    wait_valid("t4_valid", 40);
    tick(1);
    set_ch(2, 10'h001);
    tick(20);
    set_ch(2, 10'h002);
    tick(20);
    set_ch(2, 10'h003);
    tick(20);
    sb.push_back(32'h8200_0003);
    check("stalled_data", 64'(dpcr_out_data), 64'h8300_0044);
    dpcr_out_ready = 1'b1;
    wait_idle("drain_t4", 20);

    // 5: write decode, including out-of-range id and unflagged packets
    tick(1);
    for (int i = 0; i < 6; i++) begin
      dpcr_in_data  = wr_data[i];
      dpcr_in_valid = 1'b1;
      tick(1);
      dpcr_in_valid = 1'b0;
      if (wr_acc[i]) exp_out[int'(wr_data[i][27:24])] = wr_data[i][9:0];
      check("write_pio_out", 64'(pio_out), 64'(exp_pio()));
      $display("write 0x%08h -> pio_out 0x%010h", wr_data[i], pio_out);
    end
    tick(5);
    check("write_no_packet", 64'(dpcr_out_valid), 64'd0);

    // 6: asynchronous reset while a packet is stalled
    dpcr_out_ready = 1'b0;
    set_ch(1, 10'h0AA);
    wait_valid("t6_valid", 40);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(dpcr_out_valid), 64'd0);
    check("async_data", 64'(dpcr_out_data), 64'd0);
    check("async_pio_out", 64'(pio_out), 64'd0);
    pio_in = '0;
    tick(3);
    rst_n          = 1'b1;
    dpcr_out_ready = 1'b1;
    tick(40);
    check("no_stale_packet", 64'(dpcr_out_valid), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
